path_decoder_2way_buffered: RTL and testbench

Buffered, flow-controlled successor to the combinational two-way Y-axis forwarding decoder in the mesh router. It accepts packets into an internal FIFO and decodes the head packet's signed dy field. Packets with dy ≠ 0 go to the forward port with dy adjusted by ADD; packets with dy = 0 go to the local port with the dy field stripped. It sits between the router input buffer and the north/south forward link and the local core port, and adds backpressure and a delivered-packet counter.

---
 rtl/path_decoder_2way_buffered.sv | 82 ++++++++
 tb/tb_path_decoder_2way_buffered.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/path_decoder_2way_buffered.sv
// Buffered two-way Y-axis decoder: the FIFO head goes to port a (dy != 0, dy adjusted by ADD)
// or to port b (dy == 0, dy field stripped). Port b deliveries are counted.
module path_decoder_2way_buffered #(
   parameter int DATA_WIDTH = 23,
   parameter int DY_MSB     = 20,
   parameter int DY_LSB     = 12,
   parameter int ADD        = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16,
   localparam int DY_W      = DY_MSB - DY_LSB + 1,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic [DATA_WIDTH-1:0]      dout_a,
   output logic                       valid_a,
   input  logic                       ready_a,
   output logic [DATA_WIDTH-DY_W-1:0] dout_b,
   output logic                       valid_b,
   input  logic                       ready_b,
   output logic [CNT_WIDTH-1:0]       local_count,
   output logic [AW:0]                fifo_count
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic [DATA_WIDTH-1:0] head;
   logic [DY_W-1:0]       dy, dy_adj;
   logic                  empty, full, fwd_sel, push, pop;

   assign head    = mem[rptr];
   assign dy      = head[DY_MSB:DY_LSB];
   // Truncating ADD to DY_W bits gives the two's-complement step, so wrap is free.
   assign dy_adj  = dy + DY_W'(ADD);
   assign empty   = (fifo_count == '0);
   assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign fwd_sel = (dy != '0);

   assign din_ready = !full && !rst;
   assign valid_a   = !rst && !empty && fwd_sel;
   assign valid_b   = !rst && !empty && !fwd_sel;
   assign push      = din_valid && din_ready;
   assign pop       = (valid_a && ready_a) || (valid_b && ready_b);

   always_comb begin
      dout_a                = head;
      dout_a[DY_MSB:DY_LSB] = dy_adj;
   end

   generate
      if (DY_MSB == DATA_WIDTH-1) begin : g_b_low
         assign dout_b = head[DY_LSB-1:0];
      end else if (DY_LSB == 0) begin : g_b_high
         assign dout_b = head[DATA_WIDTH-1:DY_MSB+1];
      end else begin : g_b_both
         assign dout_b = {head[DATA_WIDTH-1:DY_MSB+1], head[DY_LSB-1:0]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         fifo_count  <= '0;
         local_count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
         else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
         if (pop && valid_b) local_count <= local_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_path_decoder_2way_buffered.sv
// Bench for path_decoder_2way_buffered: ADD=+1 and ADD=-1 instances share stimulus and are
// checked every cycle against a queue model, plus literal spot checks.
module tb_path_decoder_2way_buffered;

   logic        clk = 1'b0;
   logic        rst, din_valid, ready_a, ready_b;
   logic [22:0] din;
   logic [22:0] dout_a, dout_a_n;
   logic [13:0] dout_b, dout_b_n;
   logic        din_ready, din_ready_n, valid_a, valid_a_n, valid_b, valid_b_n;
   logic [15:0] local_count, local_count_n;
   logic [2:0]  fifo_count, fifo_count_n;

   int checks = 0;
   int errors = 0;

   logic [22:0] q[$];
   int          lc = 0;

   always #5 clk = ~clk;

   path_decoder_2way_buffered #(.ADD(1)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout_a(dout_a), .valid_a(valid_a), .ready_a(ready_a),
      .dout_b(dout_b), .valid_b(valid_b), .ready_b(ready_b),
      .local_count(local_count), .fifo_count(fifo_count));

   path_decoder_2way_buffered #(.ADD(-1)) dut_n (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_n),
      .dout_a(dout_a_n), .valid_a(valid_a_n), .ready_a(ready_a),
      .dout_b(dout_b_n), .valid_b(valid_b_n), .ready_b(ready_b),
      .local_count(local_count_n), .fifo_count(fifo_count_n));

   function automatic int dy_of(input logic [22:0] p);
      return $signed(p[20:12]);
   endfunction

   function automatic logic [22:0] fwd(input logic [22:0] p, input int add);
      logic [22:0] r;
      int          v;
      v         = (dy_of(p) + add) & 511;
      r         = p;
      r[20:12]  = v[8:0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state after the upcoming edge, from the inputs being applied for it.
   task automatic model_update();
      bit push_m, pop_m, loc;
      if (rst) begin
         q.delete();
         lc = 0;
      end else begin
         push_m = din_valid && (q.size() < 4);
         pop_m  = 1'b0;
         loc    = 1'b0;
         if (q.size() > 0) begin
            loc   = (dy_of(q[0]) == 0);
            pop_m = loc ? ready_b : ready_a;
         end
         if (pop_m) begin
            if (loc) lc = (lc + 1) % 65536;
            void'(q.pop_front());
         end
         if (push_m) q.push_back(din);
      end
   endtask

   task automatic compare();
      bit ev_a, ev_b;
      ev_a = 1'b0;
      ev_b = 1'b0;
      if (!rst && q.size() > 0) begin
         ev_a = (dy_of(q[0]) != 0);
         ev_b = !ev_a;
      end
      chk("din_ready",    32'(din_ready),    32'(!rst && q.size() < 4));
      chk("din_ready_n",  32'(din_ready_n),  32'(!rst && q.size() < 4));
      chk("valid_a",      32'(valid_a),      32'(ev_a));
      chk("valid_b",      32'(valid_b),      32'(ev_b));
      chk("fifo_count",   32'(fifo_count),   32'(q.size()));
      chk("fifo_count_n", 32'(fifo_count_n), 32'(q.size()));
      chk("local_count",  32'(local_count),  32'(lc));
      if (ev_a) begin
         chk("dout_a",   32'(dout_a),   32'(fwd(q[0], 1)));
         chk("dout_a_n", 32'(dout_a_n), 32'(fwd(q[0], -1)));
      end
      if (ev_b) chk("dout_b", 32'(dout_b), 32'({q[0][22:21], q[0][11:0]}));
   endtask

   task automatic tick(input logic r, input logic dv, input logic [22:0] d,
                       input logic ra, input logic rb);
      rst       = r;
      din_valid = dv;
      din       = d;
      ready_a   = ra;
      ready_b   = rb;
      model_update();
      @(negedge clk);
      compare();
   endtask

   initial begin
      logic [22:0] d;
      // reset
      tick(1, 0, 0, 0, 0);
      tick(1, 1, 23'h403123, 1, 1);
      chk("rst_fifo_count", 32'(fifo_count), 0);
      chk("rst_din_ready",  32'(din_ready), 0);
      chk("rst_valids",     32'({valid_a, valid_b}), 0);

      // single forward packet, dy=3
      tick(0, 1, 23'h403123, 1, 0);
      chk("fwd_valid_a",  32'(valid_a), 1);
      chk("fwd_dout_a",   32'(dout_a), 32'h404123);
      chk("fwd_dout_a_n", 32'(dout_a_n), 32'h402123);
      tick(0, 0, 0, 1, 0);
      chk("fwd_empty_after", 32'(fifo_count), 0);
      chk("fwd_local_count", 32'(local_count), 0);

      // local packet, dy=0
      tick(0, 1, 23'h000ABC, 0, 1);
      chk("loc_valid_b", 32'(valid_b), 1);
      chk("loc_valid_a", 32'(valid_a), 0);
      chk("loc_dout_b",  32'(dout_b), 32'h0ABC);
      tick(0, 1, 23'h600ABC, 0, 1);
      chk("loc_local_count1", 32'(local_count), 1);
      chk("loc_dout_b_upper", 32'(dout_b), 32'h3ABC);
      tick(0, 0, 0, 0, 1);
      chk("loc_local_count2", 32'(local_count), 2);

      // dy wrap at both ends
      tick(0, 1, 23'h100000, 0, 0);
      chk("wrap_neg_add1",  32'(dout_a),   32'h101000);
      chk("wrap_neg_addm1", 32'(dout_a_n), 32'h0FF000);
      tick(0, 0, 0, 1, 0);
      tick(0, 1, 23'h0FF000, 0, 0);
      chk("wrap_pos_add1",  32'(dout_a),   32'h100000);
      chk("wrap_pos_addm1", 32'(dout_a_n), 32'h0FE000);
      tick(0, 0, 0, 1, 0);

      // backpressure: fill, then no push while full even with a pop
      tick(0, 1, 23'h401001, 0, 1);
      tick(0, 1, 23'h402002, 0, 1);
      tick(0, 1, 23'h403003, 0, 1);
      tick(0, 1, 23'h404004, 0, 1);
      chk("bp_din_ready", 32'(din_ready), 0);
      chk("bp_fifo_full", 32'(fifo_count), 4);
      chk("bp_dout_hold", 32'(dout_a), 32'h402001);
      tick(0, 1, 23'h7FFFFF, 1, 0);
      chk("bp_no_bypass", 32'(fifo_count), 3);
      chk("bp_order",     32'(dout_a), 32'h403002);
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 0, 1, 0);
      chk("bp_drained", 32'(fifo_count), 0);

      // random mixed traffic
      for (int i = 0; i < 3000; i++) begin
         d = 23'($urandom);
         if ($urandom_range(0, 2) == 0) d[20:12] = '0;
         tick(0, $urandom_range(0, 9) < 7, d,
              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      end

      // mid-operation reset with 3 entries buffered
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 1);
      tick(0, 1, 23'h405000, 0, 0);
      tick(0, 1, 23'h000111, 0, 0);
      tick(0, 1, 23'h406000, 0, 0);
      chk("mr_fifo3", 32'(fifo_count), 3);
      tick(1, 1, 23'h407000, 1, 1);
      chk("mr_fifo0",  32'(fifo_count), 0);
      chk("mr_valids", 32'({valid_a, valid_b}), 0);
      chk("mr_local",  32'(local_count), 0);
      tick(0, 0, 0, 1, 1);
      chk("mr_ready_back", 32'(din_ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
